// File: rtl/edge_pkg.sv
// Shared mode encoding for the multi-channel edge detector.
// Channel i's mode field selects which filtered transitions become pulses.
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    function automatic logic rise_enabled(input mode_e m);
        return (m == MODE_RISE) || (m == MODE_BOTH);
    endfunction

    function automatic logic fall_enabled(input mode_e m);
        return (m == MODE_FALL) || (m == MODE_BOTH);
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One detector channel: synchronizer chain, stability filter, and mode-masked
// edge pulses. The *_next_o outputs let the parent count events on the same edge.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  sig_i,
    input  mode_e mode_i,
    output logic  level_o,
    output logic  rise_o,
    output logic  fall_o,
    output logic  rise_next_o,
    output logic  fall_next_o
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FCW-1:0]         cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_val;

    assign sync_val = sync_q[SYNC_STAGES-1];

    // A level change is accepted only after FILTER_LEN consecutive mismatching cycles.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_val != level_q) begin
            if (cnt_q == FILT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + FCW'(1);
            end
        end
        rise_d = level_d & ~level_q & rise_enabled(mode_i);
        fall_d = ~level_d & level_q & fall_enabled(mode_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o     = level_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign rise_next_o = rise_d;
    assign fall_next_o = fall_d;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector with a saturating event counter and
// sticky per-channel interrupt flags.
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_sig,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     irq_clr,
    input  logic                 clr_count,
    output logic [WIDTH-1:0]     rise_pulse,
    output logic [WIDTH-1:0]     fall_pulse,
    output logic [WIDTH-1:0]     level,
    output logic [CNT_W-1:0]     evt_count,
    output logic [WIDTH-1:0]     irq_status,
    output logic                 irq
);

    localparam int SW = CNT_W + $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rise_next, fall_next, evt_next;
    logic [CNT_W-1:0] evt_count_q, evt_count_d;
    logic [WIDTH-1:0] irq_status_q, irq_status_d;
    logic [SW-1:0]    n_evt, sum;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .sig_i       (in_sig[g]),
            .mode_i      (mode_e'(mode[2*g +: 2])),
            .level_o     (level[g]),
            .rise_o      (rise_pulse[g]),
            .fall_o      (fall_pulse[g]),
            .rise_next_o (rise_next[g]),
            .fall_next_o (fall_next[g])
        );
    end

    assign evt_next = rise_next | fall_next;

    always_comb begin
        n_evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n_evt = n_evt + SW'(evt_next[i]);
        end
        sum = SW'(evt_count_q) + n_evt;
        if (clr_count) begin
            evt_count_d = '0;
        end else if (sum > SW'({CNT_W{1'b1}})) begin
            evt_count_d = {CNT_W{1'b1}};
        end else begin
            evt_count_d = sum[CNT_W-1:0];
        end
        // A new event wins over a coincident clear strobe.
        irq_status_d = (irq_status_q & ~irq_clr) | evt_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_count_q  <= '0;
            irq_status_q <= '0;
        end else begin
            evt_count_q  <= evt_count_d;
            irq_status_q <= irq_status_d;
        end
    end

    assign evt_count  = evt_count_q;
    assign irq_status = irq_status_q;
    assign irq        = |irq_status_q;

endmodule
